vga_frame_capture: RTL and testbench

//  Receive-side VGA block: samples an incoming VGA stream (HSYNC/VSYNC + 4:4:4 RGB)
//  on the pixel clock and writes one CAP_W x CAP_H window of pixels into a 12-bit

---
 rtl/vga_frame_capture.sv | 160 ++++++++++++++++
 tb/tb_vga_frame_capture.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_capture.sv
// Receive-side VGA capture: registers the incoming sync/RGB stream once and writes a
// CAP_W x CAP_H window of 12-bit pixels into frame-buffer RAM, single-shot or continuous.
module vga_frame_capture #(
    parameter int H_START  = 216,
    parameter int V_START  = 27,
    parameter int CAP_W    = 600,
    parameter int CAP_H    = 500,
    parameter int ADDR_W   = 19,
    parameter int SYNC_POL = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              HSYNC,
    input  logic              VSYNC,
    input  logic [3:0]        RED,
    input  logic [3:0]        GRN,
    input  logic [3:0]        BLU,
    input  logic              arm,
    input  logic              continuous,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err
);

    localparam logic [10:0]       H_LO      = 11'(H_START);
    localparam logic [10:0]       H_HI      = 11'(H_START + CAP_W);
    localparam logic [10:0]       V_LO      = 11'(V_START);
    localparam logic [10:0]       V_HI      = 11'(V_START + CAP_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CAP_W * CAP_H - 1);
    localparam logic              POL       = (SYNC_POL != 0);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    logic              hs_p1, vs_p1, hs_dly_p1, vs_dly_p1;
    logic [11:0]       rgb_p1;
    logic [10:0]       h_cnt, v_cnt, h_now, v_now;
    logic              hs_edge, vs_edge, in_win, short_line;
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic              vld_p1, clr_ptr, err_set, err_clr, done_set, done_pend;

    // Stage 1: input register; every decision below is taken on these samples
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hs_p1     <= 1'b0;
            vs_p1     <= 1'b0;
            hs_dly_p1 <= 1'b0;
            vs_dly_p1 <= 1'b0;
            rgb_p1    <= '0;
        end else begin
            hs_p1     <= HSYNC;
            vs_p1     <= VSYNC;
            hs_dly_p1 <= hs_p1;
            vs_dly_p1 <= vs_p1;
            rgb_p1    <= {RED, GRN, BLU};
        end
    end

    assign hs_edge = (hs_p1 == POL) && (hs_dly_p1 != POL);
    assign vs_edge = (vs_p1 == POL) && (vs_dly_p1 != POL);

    // h_now/v_now are the positions of the pixel currently held in stage 1
    always_comb begin
        h_now = hs_edge ? 11'd0 : sat_inc(h_cnt);
        v_now = v_cnt;
        if (vs_edge)
            v_now = 11'd0;
        else if (hs_edge)
            v_now = sat_inc(v_cnt);
    end

    assign in_win     = (h_now >= H_LO) && (h_now < H_HI) && (v_now >= V_LO) && (v_now < V_HI);
    assign short_line = hs_edge && (h_cnt >= H_LO) && (h_cnt < H_HI);
    assign busy       = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_now;
            v_cnt <= v_now;
        end
    end

    always_comb begin
        state_nxt = state;
        vld_p1    = 1'b0;
        clr_ptr   = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        done_set  = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_nxt = ARMED;
                    err_clr   = 1'b1;
                end
            end
            ARMED: begin
                if (vs_edge) begin
                    state_nxt = CAPTURE;
                    clr_ptr   = 1'b1;
                end
            end
            CAPTURE: begin
                if (short_line || vs_edge) begin
                    state_nxt = IDLE;
                    err_set   = 1'b1;
                end else if (in_win) begin
                    vld_p1 = 1'b1;
                    if (ptr == LAST_ADDR) begin
                        done_set  = 1'b1;
                        state_nxt = continuous ? ARMED : IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage 2: RAM write port and status outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            done_pend  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (clr_ptr)
                ptr <= '0;
            else if (vld_p1 && (ptr != LAST_ADDR))
                ptr <= ptr + ADDR_W'(1);
            wr_en <= vld_p1;
            if (vld_p1) begin
                wr_addr <= ptr;
                wr_data <= rgb_p1;
            end
            done_pend  <= done_set;
            frame_done <= done_pend;
            if (err_set)
                frame_err <= 1'b1;
            else if (err_clr)
                frame_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Self-checking bench for vga_frame_capture: stream-level reference model over
// randomized and directed VGA frames, compared cycle by cycle.
module tb_vga_frame_capture;

    localparam int H_START  = 2;
    localparam int V_START  = 1;
    localparam int CAP_W    = 4;
    localparam int CAP_H    = 3;
    localparam int ADDR_W   = 19;
    localparam int SYNC_POL = 1;
    localparam int LAST     = CAP_W * CAP_H - 1;
    localparam int MAXN     = 1024;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              HSYNC = 1'b0, VSYNC = 1'b0, arm = 1'b0, continuous = 1'b0;
    logic [3:0]        RED = '0, GRN = '0, BLU = '0;
    logic              wr_en, busy, frame_done, frame_err;
    logic [ADDR_W-1:0] wr_addr;
    logic [11:0]       wr_data;

    always #5 clock = ~clock;

    vga_frame_capture #(
        .H_START(H_START), .V_START(V_START), .CAP_W(CAP_W), .CAP_H(CAP_H),
        .ADDR_W(ADDR_W), .SYNC_POL(SYNC_POL)
    ) dut (
        .clock(clock), .reset(reset), .HSYNC(HSYNC), .VSYNC(VSYNC),
        .RED(RED), .GRN(GRN), .BLU(BLU), .arm(arm), .continuous(continuous),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Stimulus stream: one entry per clock, applied to the pins in order
    bit          s_hs[MAXN], s_vs[MAXN], s_arm[MAXN], s_rst[MAXN];
    logic [11:0] s_rgb[MAXN];
    int          n;

    bit          e_wr[MAXN], e_done[MAXN], e_busy[MAXN], e_err[MAXN];
    int          e_addr[MAXN];
    logic [11:0] e_data[MAXN];

    logic              o_wr[MAXN], o_done[MAXN], o_busy[MAXN], o_err[MAXN];
    logic [ADDR_W-1:0] o_addr[MAXN];
    logic [11:0]       o_data[MAXN];

    task automatic push(input bit hs, input bit vs, input logic [11:0] rgb);
        if (n < MAXN) begin
            s_hs[n] = hs; s_vs[n] = vs; s_rgb[n] = rgb; s_arm[n] = 1'b0; s_rst[n] = 1'b0;
            n++;
        end
    endtask

    task automatic add_idle(input int k);
        for (int i = 0; i < k; i++) push(1'b0, 1'b0, 12'($urandom));
    endtask

    // Line v of a frame: HSYNC high for 2 clocks, VSYNC high for all of line 0
    task automatic add_line(input int v, input int len, input bit ramp);
        logic [11:0] px;
        for (int p = 0; p < len; p++) begin
            if (ramp && p >= H_START && p < H_START + CAP_W && v >= V_START && v < V_START + CAP_H)
                px = 12'(16 * v + p - H_START);
            else
                px = 12'($urandom);
            push(p < 2, v == 0, px);
        end
    endtask

    task automatic add_frame(input int nlines, input int short_v, input int short_len, input bit ramp);
        for (int v = 0; v < nlines; v++)
            add_line(v, (v == short_v) ? short_len : 10, ramp);
    endtask

    function automatic bit smp_hs(input int i);
        return (i >= 0 && !s_rst[i]) ? s_hs[i] : 1'b0;
    endfunction
    function automatic bit smp_vs(input int i);
        return (i >= 0 && !s_rst[i]) ? s_vs[i] : 1'b0;
    endfunction

    function automatic int sat(input int x);
        return (x > 2047) ? 2047 : x;
    endfunction

    // Reference: the sample seen at clock s is stream entry s-1 (one input register);
    // positions come from distances to the most recent sync edges in the stream.
    task automatic build_model(input bit cont);
        int mode, ptr, last_hs, line, h, hprev, i;
        bit err, pend, pend_nxt, he, ve, win;
        mode = 0; ptr = 0; last_hs = -2; line = 0; err = 1'b0; pend = 1'b0;
        for (int s = 0; s < n; s++) begin
            e_wr[s] = 1'b0; e_addr[s] = 0; e_data[s] = '0;
            if (s_rst[s]) begin
                mode = 0; ptr = 0; err = 1'b0; pend = 1'b0; last_hs = s - 1; line = 0;
                e_done[s] = 1'b0; e_busy[s] = 1'b0; e_err[s] = 1'b0;
                continue;
            end
            i = s - 1;
            he = smp_hs(i) && !smp_hs(i - 1);
            ve = smp_vs(i) && !smp_vs(i - 1);
            hprev = sat(i - 1 - last_hs);
            if (he) last_hs = i;
            h = sat(i - last_hs);
            if (ve) line = 0;
            else if (he) line = sat(line + 1);
            win = (h >= H_START) && (h < H_START + CAP_W) && (line >= V_START) && (line < V_START + CAP_H);
            pend_nxt = 1'b0;
            if (mode == 0) begin
                if (s_arm[s]) begin mode = 1; err = 1'b0; end
            end else if (mode == 1) begin
                if (ve) begin mode = 2; ptr = 0; end
            end else begin
                if ((he && hprev >= H_START && hprev < H_START + CAP_W) || ve) begin
                    mode = 0; err = 1'b1;
                end else if (win) begin
                    e_wr[s] = 1'b1; e_addr[s] = ptr; e_data[s] = s_rgb[i];
                    if (ptr == LAST) begin
                        pend_nxt = 1'b1;
                        mode = cont ? 1 : 0;
                    end else begin
                        ptr++;
                    end
                end
            end
            e_done[s] = pend;
            pend      = pend_nxt;
            e_busy[s] = (mode != 0);
            e_err[s]  = err;
        end
    endtask

    task automatic run_stream(input bit cont);
        build_model(cont);
        continuous = cont;
        for (int t = 0; t < n; t++) begin
            reset = s_rst[t]; HSYNC = s_hs[t]; VSYNC = s_vs[t]; arm = s_arm[t];
            {RED, GRN, BLU} = s_rgb[t];
            @(posedge clock); #1;
            o_wr[t] = wr_en; o_addr[t] = wr_addr; o_data[t] = wr_data;
            o_done[t] = frame_done; o_busy[t] = busy; o_err[t] = frame_err;
            check_eq("wr_en", 32'(wr_en), 32'(e_wr[t]));
            if (e_wr[t]) begin
                check_eq("wr_addr", 32'(wr_addr), 32'(e_addr[t]));
                check_eq("wr_data", 32'(wr_data), 32'(e_data[t]));
            end
            check_eq("frame_done", 32'(frame_done), 32'(e_done[t]));
            check_eq("busy", 32'(busy), 32'(e_busy[t]));
            check_eq("frame_err", 32'(frame_err), 32'(e_err[t]));
        end
        reset = 1'b0; arm = 1'b0; HSYNC = 1'b0; VSYNC = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; arm = 1'b0; HSYNC = 1'b0; VSYNC = 1'b0; continuous = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_wr_en", 32'(wr_en), 32'd0);
        check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_frame_done", 32'(frame_done), 32'd0);
        check_eq("rst_frame_err", 32'(frame_err), 32'd0);
        reset = 1'b0;
        n = 0;
    endtask

    function automatic int cnt_wr(input int a, input int b);
        int c = 0;
        for (int t = a; t < b; t++) if (o_wr[t] === 1'b1) c++;
        return c;
    endfunction
    function automatic int cnt_done(input int a, input int b);
        int c = 0;
        for (int t = a; t < b; t++) if (o_done[t] === 1'b1) c++;
        return c;
    endfunction
    function automatic int last_addr(input int a, input int b);
        int r = -1;
        for (int t = a; t < b; t++) if (o_wr[t] === 1'b1) r = int'(o_addr[t]);
        return r;
    endfunction
    function automatic int edge_data(input int a, input int b, input bit first);
        int r = -1;
        for (int t = a; t < b; t++)
            if (o_wr[t] === 1'b1 && (!first || r < 0)) r = int'(o_data[t]);
        return r;
    endfunction

    initial begin
        int fa, fb, ai, r;

        // Single-shot ramp frame
        do_reset();
        add_idle(4); s_arm[1] = 1'b1;
        add_frame(6, -1, 0, 1'b1); add_idle(6);
        run_stream(1'b0);
        check_eq("t1_writes", 32'(cnt_wr(0, n)), 32'd12);
        check_eq("t1_done_pulses", 32'(cnt_done(0, n)), 32'd1);
        check_eq("t1_first_data", 32'(edge_data(0, n, 1'b1)), 32'h010);
        check_eq("t1_last_data", 32'(edge_data(0, n, 1'b0)), 32'h033);
        check_eq("t1_last_addr", 32'(last_addr(0, n)), 32'd11);
        check_eq("t1_busy_after", 32'(o_busy[n-1]), 32'd0);

        // Unarmed frames, then arm in the middle of a frame
        do_reset();
        add_idle(3);
        repeat (3) add_frame(6, -1, 0, 1'b0);
        fa = n; add_frame(6, -1, 0, 1'b0);
        fb = n; add_frame(6, -1, 0, 1'b1); add_idle(6);
        s_arm[fa + $urandom_range(15, 45)] = 1'b1;
        run_stream(1'b0);
        check_eq("t2_no_writes_unarmed", 32'(cnt_wr(0, fb)), 32'd0);
        check_eq("t2_busy_unarmed", 32'(o_busy[fa-1]), 32'd0);
        check_eq("t2_writes", 32'(cnt_wr(fb, n)), 32'd12);
        check_eq("t2_done_pulses", 32'(cnt_done(0, n)), 32'd1);

        // Continuous capture over three frames
        do_reset();
        add_idle(3); s_arm[1] = 1'b1;
        repeat (3) add_frame(6, -1, 0, 1'b1);
        add_idle(4);
        run_stream(1'b1);
        check_eq("t3_writes", 32'(cnt_wr(0, n)), 32'd36);
        check_eq("t3_done_pulses", 32'(cnt_done(0, n)), 32'd3);
        check_eq("t3_busy_held", 32'(o_busy[n-1]), 32'd1);

        // Short third captured line, then re-arm
        do_reset();
        add_idle(3); s_arm[1] = 1'b1;
        add_frame(6, 3, 4, 1'b1); add_idle(5);
        ai = n + 2; add_idle(5); s_arm[ai] = 1'b1;
        add_frame(6, -1, 0, 1'b1); add_idle(6);
        run_stream(1'b0);
        check_eq("t4_writes_before_err", 32'(cnt_wr(0, ai)), 32'd10);
        check_eq("t4_last_addr", 32'(last_addr(0, ai)), 32'd9);
        check_eq("t4_no_done", 32'(cnt_done(0, ai)), 32'd0);
        check_eq("t4_err_set", 32'(o_err[ai-1]), 32'd1);
        check_eq("t4_idle_after_err", 32'(o_busy[ai-1]), 32'd0);
        check_eq("t4_err_cleared_by_arm", 32'(o_err[ai]), 32'd0);
        check_eq("t4_writes_after_arm", 32'(cnt_wr(ai, n)), 32'd12);

        // Short frame: VSYNC after two captured lines
        do_reset();
        add_idle(3); s_arm[1] = 1'b1;
        add_frame(3, -1, 0, 1'b1); add_frame(6, -1, 0, 1'b1); add_idle(3);
        ai = n + 1; add_idle(3); s_arm[ai] = 1'b1;
        add_frame(6, -1, 0, 1'b1); add_idle(6);
        run_stream(1'b0);
        check_eq("t5_writes_before_err", 32'(cnt_wr(0, ai)), 32'd8);
        check_eq("t5_last_addr", 32'(last_addr(0, ai)), 32'd7);
        check_eq("t5_err_set", 32'(o_err[ai-1]), 32'd1);
        check_eq("t5_no_done", 32'(cnt_done(0, ai)), 32'd0);
        check_eq("t5_writes_after_arm", 32'(cnt_wr(ai, n)), 32'd12);

        // Reset in the middle of a capture
        do_reset();
        add_idle(3); s_arm[1] = 1'b1;
        fa = n; add_frame(6, -1, 0, 1'b1);
        r = fa + 25; s_rst[r] = 1'b1; s_rst[r+1] = 1'b1;
        add_idle(2); ai = n; add_idle(2); s_arm[ai] = 1'b1;
        add_frame(6, -1, 0, 1'b1); add_idle(6);
        run_stream(1'b0);
        check_eq("t6_last_addr_before_rst", 32'(last_addr(0, r)), 32'd5);
        check_eq("t6_rst_wr_en", 32'(o_wr[r]), 32'd0);
        check_eq("t6_rst_wr_addr", 32'(o_addr[r]), 32'd0);
        check_eq("t6_rst_busy", 32'(o_busy[r]), 32'd0);
        check_eq("t6_writes_after_rst", 32'(cnt_wr(r, n)), 32'd12);
        check_eq("t6_done_pulses", 32'(cnt_done(0, n)), 32'd1);

        // Randomized frames, short lines/frames and arm pulses
        for (int k = 0; k < 4; k++) begin
            bit cont;
            do_reset();
            cont = 1'($urandom_range(0, 1));
            add_idle($urandom_range(2, 6));
            for (int f = 0; f < 4; f++) begin
                int sv;
                sv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : -1;
                add_frame(($urandom_range(0, 4) == 0) ? 3 : 6, sv, $urandom_range(3, 9), 1'b0);
            end
            add_idle(5);
            for (int a = 0; a < 4; a++) s_arm[$urandom_range(0, n - 1)] = 1'b1;
            run_stream(cont);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
